// File: rtl/aes_enc_if.sv
// rtl/aes_enc_if.sv - host/data-path signal bundle for the aes_enc core
interface aes_enc_if;
  logic         keylength128;
  logic         keylength192;
  logic         keylength256;
  logic [0:127] plaintext;
  logic [0:255] cipherkey;
  logic         plaintext_dv;
  logic         cipherkey_dv;
  logic [0:127] ciphertext;
  logic         ciphertext_dv;
  logic         busy_enc;
  logic         busy_exp;

  modport master (
    output keylength128, keylength192, keylength256,
    output plaintext, cipherkey, plaintext_dv, cipherkey_dv,
    input  ciphertext, ciphertext_dv, busy_enc, busy_exp
  );

  modport slave (
    input  keylength128, keylength192, keylength256,
    input  plaintext, cipherkey, plaintext_dv, cipherkey_dv,
    output ciphertext, ciphertext_dv, busy_enc, busy_exp
  );
endinterface

// File: rtl/aes_enc.sv
// rtl/aes_enc.sv - iterative AES encryptor, one key word or one round per clock
// AES_ENC_LONGKEY_EN enables 192/256-bit keys; without it every key is treated as 128-bit.
module aes_enc (
  input  logic     mclk,
  input  logic     arst,
  aes_enc_if.slave bus
);

`ifdef AES_ENC_LONGKEY_EN
  localparam int WORDS = 60;
`else
  localparam int WORDS = 44;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXP, S_ENC} state_t;

  state_t               state, next_state;
  logic [WORDS*32-1:0]  w_flat;
  logic [127:0]         st, ct_q, rk;
  logic [255:0]         key_v;
  logic [127:0]         pt_v;
  logic                 ct_dv_q, key_valid;
  logic [3:0]           nk, nr, round, sel_nk, sel_nr;
  logic [5:0]           widx, prev_idx, old_idx, rk_base;
  logic [2:0]           mod_cnt;
  logic [7:0]           rcon;
  logic [31:0]          prev_w, old_w, rot_in, sw, temp;
  logic                 start_exp, start_enc, exp_last, enc_last;
  logic                 unused_klen;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    y = a;
    for (int k = 0; k < 6; k++) y = gf_mul(gf_mul(y, y), a);
    y = gf_mul(y, y);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the state sits at row n%4, column n/4; byte 0 is the MSB.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    int src;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      src = (n % 4) + 4 * (((n / 4) + (n % 4)) % 4);
      r[127-8*n -: 8] = sbox(s[127-8*src -: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign key_v       = bus.cipherkey;
  assign pt_v        = bus.plaintext;
  assign unused_klen = ^{bus.keylength128, bus.keylength192, bus.keylength256};

`ifdef AES_ENC_LONGKEY_EN
  always_comb begin
    sel_nk = 4'd4;
    if (bus.keylength256)      sel_nk = 4'd8;
    else if (bus.keylength192) sel_nk = 4'd6;
    sel_nr = sel_nk + 4'd6;
  end
`else
  assign sel_nk = 4'd4;
  assign sel_nr = 4'd10;
`endif

  assign rk_base = {round, 2'b00};
  assign rk = {w_flat[{rk_base, 5'd0} +: 32],
               w_flat[{rk_base + 6'd1, 5'd0} +: 32],
               w_flat[{rk_base + 6'd2, 5'd0} +: 32],
               w_flat[{rk_base + 6'd3, 5'd0} +: 32]};

  assign prev_idx = widx - 6'd1;
  assign old_idx  = widx - {2'b00, nk};
  assign prev_w   = w_flat[{prev_idx, 5'd0} +: 32];
  assign old_w    = w_flat[{old_idx, 5'd0} +: 32];
  assign rot_in   = (mod_cnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign sw       = sub_word(rot_in);

  always_comb begin
    temp = prev_w;
    if (mod_cnt == 3'd0)                       temp = sw ^ {rcon, 24'h0};
    else if (nk == 4'd8 && mod_cnt == 3'd4)    temp = sw;
  end

  assign exp_last = (widx == {nr, 2'b11});
  assign enc_last = (round == nr);

  always_ff @(posedge mclk or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_exp  = 1'b0;
    start_enc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cipherkey_dv) begin
          start_exp  = 1'b1;
          next_state = S_EXP;
        end else if (bus.plaintext_dv && key_valid) begin
          start_enc  = 1'b1;
          next_state = S_ENC;
        end
      end
      S_EXP:   if (exp_last) next_state = S_IDLE;
      S_ENC:   if (enc_last) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge arst) begin
    if (arst) begin
      w_flat    <= '0;
      st        <= '0;
      ct_q      <= '0;
      ct_dv_q   <= 1'b0;
      key_valid <= 1'b0;
      nk        <= 4'd4;
      nr        <= 4'd10;
      round     <= 4'd0;
      widx      <= 6'd0;
      mod_cnt   <= 3'd0;
      rcon      <= 8'h01;
    end else begin
      ct_dv_q <= 1'b0;
      if (start_exp) begin
        nk        <= sel_nk;
        nr        <= sel_nr;
        key_valid <= 1'b0;
        widx      <= {2'b00, sel_nk};
        mod_cnt   <= 3'd0;
        rcon      <= 8'h01;
        // Words beyond Nk are overwritten by the schedule before being read.
        for (int k = 0; k < 8; k++) w_flat[32*k +: 32] <= key_v[255-32*k -: 32];
      end else if (state == S_EXP) begin
        w_flat[{widx, 5'd0} +: 32] <= old_w ^ temp;
        mod_cnt <= ({1'b0, mod_cnt} == nk - 4'd1) ? 3'd0 : mod_cnt + 3'd1;
        if (mod_cnt == 3'd0) rcon <= xtime(rcon);
        if (exp_last) key_valid <= 1'b1;
        else          widx <= widx + 6'd1;
      end

      if (start_enc) begin
        st    <= pt_v ^ rk;
        round <= 4'd1;
      end else if (state == S_ENC) begin
        if (enc_last) begin
          ct_q    <= sub_shift(st) ^ rk;
          ct_dv_q <= 1'b1;
          round   <= 4'd0;
        end else begin
          st    <= mix_cols(sub_shift(st)) ^ rk;
          round <= round + 4'd1;
        end
      end
    end
  end

  assign bus.ciphertext    = ct_q;
  assign bus.ciphertext_dv = ct_dv_q;
  assign bus.busy_enc      = (state == S_ENC);
  assign bus.busy_exp      = (state == S_EXP);
endmodule

// File: tb/tb_aes_enc.sv
// tb/tb_aes_enc.sv - randomized self-checking bench for aes_enc against a byte-level AES model
module tb_aes_enc;
`ifdef AES_ENC_LONGKEY_EN
  localparam bit LONGKEY = 1'b1;
`else
  localparam bit LONGKEY = 1'b0;
`endif

  localparam logic [255:0] K128  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT128 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic mclk = 1'b0;
  logic arst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] m_w [240];
  int         m_nr;

  aes_enc_if bus ();
  aes_enc dut (.mclk(mclk), .arst(arst), .bus(bus));

  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expd);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box by walking powers of the generator 3 and of its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic int nk_of(input logic [2:0] flags);
    if (!LONGKEY) return 4;
    return flags[2] ? 8 : (flags[1] ? 6 : 4);
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [7:0] t [4];
    logic [7:0] tmp, rc;
    m_nr = nk + 6;
    rc   = 8'h01;
    for (int i = 0; i < 4 * nk; i++) m_w[i] = key[255-8*i -: 8];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      for (int j = 0; j < 4; j++) t[j] = m_w[4*(i-1)+j];
      if (i % nk == 0) begin
        tmp  = t[0];
        t[0] = sbox_t[t[1]] ^ rc;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[tmp];
        rc   = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sbox_t[t[j]];
      end
      for (int j = 0; j < 4; j++) m_w[4*i+j] = m_w[4*(i-nk)+j] ^ t[j];
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ m_w[n];
    for (int rnd = 1; rnd <= m_nr; rnd++) begin
      for (int n = 0; n < 16; n++) u[n] = sbox_t[s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (rnd < m_nr) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ m_w[16*rnd+n];
    end
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
    return r;
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // mode 0: plain load; 1: plaintext strobe during expansion; 2: both strobes together.
  task automatic new_key(input logic [255:0] key, input logic [2:0] flags, input int mode, input string tag);
    int n, stray, nk;
    nk = nk_of(flags);
    model_expand(key, nk);
    bus.cipherkey = key;
    {bus.keylength256, bus.keylength192, bus.keylength128} = flags;
    bus.cipherkey_dv = 1'b1;
    if (mode == 2) begin
      bus.plaintext    = rand_block();
      bus.plaintext_dv = 1'b1;
    end
    @(negedge mclk);
    bus.cipherkey_dv = 1'b0;
    bus.plaintext_dv = 1'b0;
    n = 0;
    stray = 0;
    while (bus.busy_exp && n < 200) begin
      if (bus.busy_enc || bus.ciphertext_dv) stray++;
      bus.plaintext_dv = (mode == 1 && n == 5);
      @(negedge mclk);
      n++;
    end
    bus.plaintext_dv = 1'b0;
    repeat (3) begin
      if (bus.busy_enc || bus.ciphertext_dv) stray++;
      @(negedge mclk);
    end
    check({tag, "_exp_cycles"}, n, 4 * (nk + 7) - nk);
    check({tag, "_exp_stray"}, stray, 0);
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [127:0] expd, input int exp_lat, input string tag);
    int lat;
    bus.plaintext    = pt;
    bus.plaintext_dv = 1'b1;
    @(negedge mclk);
    bus.plaintext_dv = 1'b0;
    check({tag, "_busy_enc"}, bus.busy_enc, 1);
    lat = 0;
    while (!bus.ciphertext_dv && lat < 100) begin
      @(negedge mclk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ct"}, bus.ciphertext, expd);
  endtask

  task automatic probe_ignored(input string tag);
    int stray;
    stray = 0;
    bus.plaintext    = rand_block();
    bus.plaintext_dv = 1'b1;
    @(negedge mclk);
    bus.plaintext_dv = 1'b0;
    repeat (15) begin
      if (bus.busy_enc || bus.ciphertext_dv) stray++;
      @(negedge mclk);
    end
    check(tag, stray, 0);
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] pt, expd;
    logic [2:0]   flags;

    build_sbox();
    bus.keylength128 = 1'b0;
    bus.keylength192 = 1'b0;
    bus.keylength256 = 1'b0;
    bus.plaintext    = '0;
    bus.cipherkey    = '0;
    bus.plaintext_dv = 1'b0;
    bus.cipherkey_dv = 1'b0;
    arst = 1'b1;
    repeat (3) @(negedge mclk);
    check("rst_ct", bus.ciphertext, 0);
    check("rst_ct_dv", bus.ciphertext_dv, 0);
    check("rst_busy_enc", bus.busy_enc, 0);
    check("rst_busy_exp", bus.busy_exp, 0);
    arst = 1'b0;
    @(negedge mclk);

    probe_ignored("pt_before_key");

    new_key(K128, 3'b001, 0, "fips128");
    check("rk1", {dut.w_flat[4*32 +: 32], dut.w_flat[5*32 +: 32],
                  dut.w_flat[6*32 +: 32], dut.w_flat[7*32 +: 32]},
          128'ha0fafe1788542cb123a339392a6c7605);
    check("rk10", {dut.w_flat[40*32 +: 32], dut.w_flat[41*32 +: 32],
                   dut.w_flat[42*32 +: 32], dut.w_flat[43*32 +: 32]},
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    encrypt(PT128, CT128, 10, "fips128");
    @(negedge mclk);
    check("dv_one_cycle", bus.ciphertext_dv, 0);
    check("ct_hold", bus.ciphertext, CT128);

    key = rand_key();
    new_key(key, 3'b001, 1, "drop_during_exp");
    pt = rand_block();
    encrypt(pt, model_encrypt(pt), m_nr, "after_drop");

    key = rand_key();
    new_key(key, 3'b100, 2, "simul_strobes");
    pt = rand_block();
    encrypt(pt, model_encrypt(pt), m_nr, "after_simul");

    new_key(K192, 3'b010, 0, "fips192");
    expd = LONGKEY ? CT192 : model_encrypt(PT2);
    encrypt(PT2, expd, m_nr, "fips192");

    new_key(K256, 3'b100, 0, "fips256");
    expd = LONGKEY ? CT256 : model_encrypt(PT2);
    encrypt(PT2, expd, m_nr, "fips256");
    for (int b = 0; b < 5; b++) begin
      pt = rand_block();
      encrypt(pt, model_encrypt(pt), m_nr, "b2b");
    end
    @(negedge mclk);
    check("b2b_dv_one_cycle", bus.ciphertext_dv, 0);

    for (int t = 0; t < 6; t++) begin
      flags = 3'($urandom_range(0, 7));
      key   = rand_key();
      new_key(key, flags, 0, "rand_key");
      for (int b = 0; b < 3; b++) begin
        pt = rand_block();
        encrypt(pt, model_encrypt(pt), m_nr, "rand");
      end
    end

    bus.plaintext    = rand_block();
    bus.plaintext_dv = 1'b1;
    @(negedge mclk);
    bus.plaintext_dv = 1'b0;
    repeat (4) @(negedge mclk);
    check("mid_busy_enc", bus.busy_enc, 1);
    arst = 1'b1;
    #1;
    check("mid_rst_ct", bus.ciphertext, 0);
    check("mid_rst_ct_dv", bus.ciphertext_dv, 0);
    check("mid_rst_busy_enc", bus.busy_enc, 0);
    check("mid_rst_busy_exp", bus.busy_exp, 0);
    @(negedge mclk);
    arst = 1'b0;
    @(negedge mclk);
    probe_ignored("pt_after_reset");

    new_key(K128, 3'b000, 0, "rekey_default");
    encrypt(PT128, CT128, 10, "rekey_default");
    @(negedge mclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
